// File: rtl/dpi_stream_feeder.sv
// dpi_stream_feeder: maps flow keys to stream ids and sequences the category matchers per packet.
module dpi_stream_feeder #(
    parameter int                 NUM_CAT      = 8,
    parameter int                 NUM_STREAMS  = 64,
    parameter int                 KEY_W        = 16,
    parameter int                 EOP_GAP      = 2,
    parameter logic [NUM_CAT-1:0] DEFAULT_MASK = '1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         pkt_data,
    input  logic [KEY_W-1:0]   pkt_flow_key,
    input  logic               pkt_sop,
    input  logic               pkt_eop,
    input  logic               pkt_vld,
    output logic               pkt_rdy,
    input  logic               cfg_we,
    input  logic [5:0]         cfg_stream,
    input  logic [NUM_CAT-1:0] cfg_mask,
    output logic [7:0]         char_in,
    output logic               char_in_vld,
    output logic               load_state,
    output logic               eop,
    output logic [5:0]         stream_id,
    output logic               new_stream_id,
    output logic [NUM_CAT-1:0] enable,
    input  logic [NUM_CAT-1:0] fired,
    output logic               res_vld,
    input  logic               res_rdy,
    output logic [5:0]         res_stream_id,
    output logic               res_new,
    output logic [NUM_CAT-1:0] res_fired,
    output logic [15:0]        drop_cnt
);
    localparam int GW = $clog2(EOP_GAP + 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, LOAD, PRIME, STREAM, DRAIN, EOP, RESULT} state_t;
    state_t state, state_nx;

    logic [NUM_STREAMS-1:0] tbl_vld;
    logic [KEY_W-1:0]       tbl_key  [NUM_STREAMS];
    logic [NUM_CAT-1:0]     tbl_mask [NUM_STREAMS];
    logic [KEY_W-1:0]       key_r;
    logic [5:0]             alloc_ptr;
    logic [5:0]             hit_idx;
    logic                   hit;
    logic [GW-1:0]          gap_cnt;

    // keys are only allocated on a miss, so at most one entry can match
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (tbl_vld[i] && tbl_key[i] == key_r) begin
                hit     = 1'b1;
                hit_idx = 6'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        pkt_rdy    = 1'b0;
        load_state = 1'b0;
        eop        = 1'b0;
        res_vld    = 1'b0;
        case (state)
            IDLE: begin
                pkt_rdy = rst_n & pkt_vld & ~pkt_sop;
                if (pkt_vld && pkt_sop) state_nx = LOOKUP;
            end
            LOOKUP: state_nx = LOAD;
            LOAD: begin
                load_state = 1'b1;
                state_nx   = PRIME;
            end
            PRIME: state_nx = STREAM;
            STREAM: begin
                pkt_rdy = rst_n;
                if (pkt_vld && pkt_eop) state_nx = DRAIN;
            end
            DRAIN: if (gap_cnt == GW'(EOP_GAP)) state_nx = EOP;
            EOP: begin
                eop      = 1'b1;
                state_nx = RESULT;
            end
            RESULT: begin
                res_vld = 1'b1;
                if (res_rdy) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tbl_vld       <= '0;
            alloc_ptr     <= '0;
            key_r         <= '0;
            stream_id     <= '0;
            new_stream_id <= 1'b0;
            enable        <= '0;
            char_in       <= '0;
            char_in_vld   <= 1'b0;
            gap_cnt       <= '0;
            res_stream_id <= '0;
            res_new       <= 1'b0;
            res_fired     <= '0;
            drop_cnt      <= '0;
        end else begin
            char_in_vld <= state == STREAM && pkt_vld;
            if (state == STREAM && pkt_vld) char_in <= pkt_data;
            if (state == IDLE && pkt_vld && !pkt_sop && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
            if (state == IDLE && pkt_sop) key_r <= pkt_flow_key;
            if (state == LOOKUP) begin
                stream_id     <= hit ? hit_idx : alloc_ptr;
                new_stream_id <= ~hit;
                if (!hit) begin
                    tbl_vld[alloc_ptr] <= 1'b1;
                    alloc_ptr          <= alloc_ptr == 6'(NUM_STREAMS - 1) ? '0 : alloc_ptr + 6'd1;
                end
            end
            if (state == LOAD) enable <= tbl_mask[stream_id];
            gap_cnt <= state == DRAIN ? gap_cnt + 1'b1 : '0;
            if (state == EOP) begin
                res_fired     <= fired & enable;
                res_stream_id <= stream_id;
                res_new       <= new_stream_id;
            end
        end
    end

    // cfg is applied after the allocation so a same-cycle write to the new entry keeps its mask
    always_ff @(posedge clk) begin
        if (rst_n && state == LOOKUP && !hit) begin
            tbl_key[alloc_ptr]  <= key_r;
            tbl_mask[alloc_ptr] <= DEFAULT_MASK;
        end
        if (rst_n && cfg_we && int'(cfg_stream) < NUM_STREAMS) tbl_mask[cfg_stream] <= cfg_mask;
    end
endmodule

// File: tb/tb_dpi_stream_feeder.sv
// tb_dpi_stream_feeder: directed checks of lookup/allocation, matcher sequencing, results and drops.
module tb_dpi_stream_feeder;
    localparam int EOP_GAP = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pkt_data = '0;
    logic [15:0] pkt_flow_key = '0;
    logic        pkt_sop = 1'b0, pkt_eop = 1'b0, pkt_vld = 1'b0, pkt_rdy;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_stream = '0;
    logic [7:0]  cfg_mask = '0;
    logic [7:0]  char_in;
    logic        char_in_vld, load_state, eop, new_stream_id, res_vld, res_new;
    logic        res_rdy = 1'b0;
    logic [5:0]  stream_id, res_stream_id;
    logic [7:0]  enable, res_fired;
    logic [7:0]  fired = '0;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_fail = 0;

    dpi_stream_feeder #(.EOP_GAP(EOP_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .pkt_data(pkt_data), .pkt_flow_key(pkt_flow_key),
        .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy),
        .cfg_we(cfg_we), .cfg_stream(cfg_stream), .cfg_mask(cfg_mask),
        .char_in(char_in), .char_in_vld(char_in_vld), .load_state(load_state), .eop(eop),
        .stream_id(stream_id), .new_stream_id(new_stream_id), .enable(enable), .fired(fired),
        .res_vld(res_vld), .res_rdy(res_rdy), .res_stream_id(res_stream_id), .res_new(res_new),
        .res_fired(res_fired), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {pkt_rdy, char_in_vld, load_state, eop, new_stream_id, res_vld, res_new}, 0);
        chk({tag, "_sid"}, {stream_id, res_stream_id}, 0);
        chk({tag, "_dat"}, {char_in, enable, res_fired}, 0);
        chk({tag, "_drop"}, drop_cnt, 0);
    endtask

    // Drives one packet from IDLE and stops once the result is presented (res_rdy left to caller).
    task automatic run_pkt(input logic [15:0] key, input int n, input logic [5:0] esid, input logic enew,
                           input logic [7:0] een, input logic [7:0] fv,
                           input bit cfg_lk, input logic [5:0] cs, input logic [7:0] cm);
        int bi = 0, cnt = 0, t_load = -1, t_first = -1, t_last = -1, t_eop = -1, t_res = -1;
        bit acc;
        logic [7:0] exp_c;
        fired = fv;
        pkt_vld = 1'b1; pkt_sop = 1'b1; pkt_eop = (n == 1); pkt_flow_key = key; pkt_data = key[7:0];
        for (int c = 0; c < 60 && t_res < 0; c++) begin
            #1;
            if (c == 1 && cfg_lk) begin
                cfg_we = 1'b1; cfg_stream = cs; cfg_mask = cm;
            end
            if (load_state) begin
                t_load = c;
                chk("ld_sid", stream_id, esid);
                chk("ld_new", new_stream_id, enew);
            end
            if (char_in_vld) begin
                exp_c = key[7:0] + 8'(cnt);
                chk("char", char_in, exp_c);
                if (cnt == 0) t_first = c;
                t_last = c;
                cnt++;
            end
            if (eop) begin
                t_eop = c;
                chk("eop_en", enable, een);
                chk("eop_sid", stream_id, esid);
            end
            if (res_vld) begin
                t_res = c;
                chk("res_sid", res_stream_id, esid);
                chk("res_new", res_new, enew);
                chk("res_fired", res_fired, fv & een);
            end else begin
                acc = pkt_vld & pkt_rdy;
                @(negedge clk);
                cfg_we = 1'b0;
                if (acc) begin
                    bi++;
                    pkt_sop = 1'b0;
                    pkt_data = key[7:0] + 8'(bi);
                    pkt_eop = (bi == n - 1);
                    if (bi >= n) begin
                        pkt_vld = 1'b0; pkt_eop = 1'b0;
                    end
                end
            end
        end
        chk("t_load", t_load, 2);
        chk("t_first", t_first, 5);
        chk("nchar", cnt, n);
        chk("t_last", t_last, 4 + n);
        chk("t_eop", t_eop, 4 + n + EOP_GAP + 1);
        chk("t_res", t_res, 4 + n + EOP_GAP + 2);
    endtask

    task automatic accept_result();
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
        #1 chk("res_clr", res_vld, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pkt_vld = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0; cfg_we = 1'b0; res_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit act;
        repeat (3) @(negedge clk);
        #1 chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_pkt(16'h1234, 5, 6'd0, 1'b1, 8'hFF, 8'h00, 0, 6'd0, 8'h00);
        accept_result();
        run_pkt(16'h1234, 3, 6'd0, 1'b0, 8'hFF, 8'h3C, 0, 6'd0, 8'h00);
        accept_result();
        run_pkt(16'h5678, 2, 6'd1, 1'b1, 8'hFF, 8'h00, 0, 6'd0, 8'h00);
        accept_result();

        cfg_we = 1'b1; cfg_stream = 6'd0; cfg_mask = 8'h05;
        @(negedge clk);
        cfg_we = 1'b0;
        run_pkt(16'h1234, 1, 6'd0, 1'b0, 8'h05, 8'hFF, 0, 6'd0, 8'h00);
        accept_result();

        // result back-pressure with the next sop already waiting
        run_pkt(16'h5678, 2, 6'd1, 1'b0, 8'hFF, 8'hFF, 0, 6'd0, 8'h00);
        pkt_vld = 1'b1; pkt_sop = 1'b1; pkt_flow_key = 16'h1234; pkt_data = 8'h34;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("hold_vld", res_vld, 1);
            chk("hold_res", {res_stream_id, res_new, res_fired}, {6'd1, 1'b0, 8'hFF});
            chk("hold_rdy_ld", {pkt_rdy, load_state}, 0);
        end
        accept_result();
        run_pkt(16'h1234, 4, 6'd0, 1'b0, 8'h05, 8'h0F, 0, 6'd0, 8'h00);
        accept_result();

        // cfg write landing on the entry being allocated
        run_pkt(16'h9ABC, 2, 6'd2, 1'b1, 8'h11, 8'hFF, 1, 6'd2, 8'h11);
        accept_result();
        cfg_we = 1'b1; cfg_stream = 6'd2; cfg_mask = 8'h22;
        @(negedge clk);
        cfg_we = 1'b0;
        #1 chk("en_held", enable, 8'h11);
        @(negedge clk);
        run_pkt(16'h9ABC, 1, 6'd2, 1'b0, 8'h22, 8'hFF, 0, 6'd0, 8'h00);
        accept_result();

        do_reset();
        for (int i = 0; i < 65; i++) begin
            run_pkt(16'h1000 + 16'(i), 1, 6'(i % 64), 1'b1, 8'hFF, 8'(i), 0, 6'd0, 8'h00);
            accept_result();
        end
        run_pkt(16'h1000, 1, 6'd1, 1'b1, 8'hFF, 8'h00, 0, 6'd0, 8'h00);
        accept_result();
        run_pkt(16'h1040, 1, 6'd0, 1'b0, 8'hFF, 8'h00, 0, 6'd0, 8'h00);
        accept_result();

        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            pkt_vld = 1'b1; pkt_sop = 1'b0; pkt_data = 8'h55;
            #1 chk("drop_rdy", pkt_rdy, 1);
            @(negedge clk);
            #1 chk("drop_quiet", {char_in_vld, load_state}, 0);
        end
        pkt_vld = 1'b0;
        @(negedge clk);
        #1 chk("drop_cnt", drop_cnt, 3);

        // reset while streaming
        @(negedge clk);
        pkt_vld = 1'b1; pkt_sop = 1'b1; pkt_flow_key = 16'h4444; pkt_data = 8'h44;
        repeat (5) @(negedge clk);
        pkt_sop = 1'b0; pkt_data = 8'h45;
        #1 chk("mid_stream", char_in_vld, 1);
        rst_n = 1'b0; pkt_vld = 1'b0;
        @(negedge clk);
        #1 chk_zero("rst_mid");
        rst_n = 1'b1;
        act = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1 act |= res_vld | load_state | eop;
        end
        chk("no_result", act, 0);
        run_pkt(16'h1040, 1, 6'd0, 1'b1, 8'hFF, 8'h00, 0, 6'd0, 8'h00);
        accept_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dpi_stream_feeder.md
Name: dpi_stream_feeder

Overview:
- Feeds the per-category regex matchers that sit behind it.
- Accepts byte-wide packets tagged with a flow key and maps each key to a 6-bit stream_id through a small associative stream table.
- Sequences the matcher interface for each packet: load_state, then char stream, then eop, keeping stream_id, new_stream_id and enable stable for the whole packet.
- Collects the matchers' fired vector at eop and emits one result record per packet.

Parameters:
NUM_CAT, 8, number of attached category matchers (width of enable/fired)
NUM_STREAMS, 64, stream table entries (2..64; stream_id is always 6 bits)
KEY_W, 16, flow key width
EOP_GAP, 2, idle cycles between last char_in_vld and eop pulse (>=1)
DEFAULT_MASK, all ones, enable mask loaded into a newly allocated entry

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
pkt_data  in  8  packet byte
pkt_flow_key  in  KEY_W  flow key; valid when pkt_sop=1
pkt_sop  in  1  first byte of packet
pkt_eop  in  1  last byte of packet
pkt_vld  in  1  byte valid
pkt_rdy  out  1  byte accepted when pkt_vld & pkt_rdy
cfg_we  in  1  enable-mask write strobe
cfg_stream  in  6  entry to write
cfg_mask  in  NUM_CAT  new enable mask
char_in  out  8  to matchers, registered
char_in_vld  out  1  to matchers, registered
load_state  out  1  one-cycle pulse at packet start
eop  out  1  one-cycle pulse at packet end
stream_id  out  6  held from load_state through eop
new_stream_id  out  1  1 = table miss / fresh allocation
enable  out  NUM_CAT  per-category enable, latched at LOAD
fired  in  NUM_CAT  matcher speculative-match flags
res_vld  out  1  result valid
res_rdy  in  1  result accepted when res_vld & res_rdy
res_stream_id  out  6  stream of the result
res_new  out  1  packet opened a new stream
res_fired  out  NUM_CAT  fired & enable sampled in eop cycle
drop_cnt  out  16  saturating count of bytes dropped outside a packet

Behaviour:
- Reset:
  - All table valid bits are cleared; alloc_ptr=0; FSM goes to IDLE.
  - Every output is 0 and drop_cnt=0.
  - Reset mid-packet abandons the packet with no result. The matchers share rst_n.
- IDLE state:
  - pkt_rdy=1 only when pkt_vld & ~pkt_sop. Such a byte is dropped and drop_cnt increments, saturating at 0xFFFF.
  - pkt_vld & pkt_sop moves to LOOKUP. The sop byte is not consumed.
- LOOKUP state (1 cycle, pkt_rdy=0):
  - The key is compared against all valid entries.
  - Hit at index i: stream_id=i, new_stream_id=0.
  - Miss: stream_id=alloc_ptr, new_stream_id=1. The entry is written {valid, key, DEFAULT_MASK}, and alloc_ptr increments, wrapping from NUM_STREAMS-1 to 0. A valid entry at that index is evicted.
  - Multiple hits cannot occur, because a key is only allocated on a miss.
- LOAD state (1 cycle):
  - load_state=1.
  - enable is latched from the entry's mask and held until the next LOAD.
- PRIME state (1 cycle): idle. This lets the matcher restore state before the first character.
- STREAM state:
  - pkt_rdy=1.
  - An accepted byte appears on char_in with char_in_vld=1 on the next cycle. When pkt_vld=0, char_in_vld=0 on the next cycle.
  - An accepted byte with pkt_eop=1 moves to DRAIN.
  - A second pkt_sop inside STREAM is treated as data; there is no recovery.
- DRAIN state: counts EOP_GAP cycles with char_in_vld=0, then moves to EOP.
- EOP state (1 cycle):
  - eop=1.
  - res_fired <= fired & enable, and res_stream_id / res_new are captured.
  - Moves to RESULT.
- RESULT state:
  - res_vld=1 and held with stable data until res_rdy. pkt_rdy=0.
  - On handshake, returns to IDLE. The earliest next LOAD is 3 cycles later (RESULT -> IDLE -> LOOKUP -> LOAD).
- Single-byte packet (sop & eop on one byte): legal. Sequence is LOOKUP, LOAD, PRIME, STREAM accepting 1 byte, DRAIN, EOP.
- Latency: the sop byte reaches char_in 4 cycles after pkt_sop is first seen in IDLE.
- cfg writes:
  - Applied any cycle and take effect at the entry's next LOAD.
  - A cfg write to the entry being allocated in the same cycle wins: mask = cfg_mask, valid/key from the allocation.
  - cfg_stream >= NUM_STREAMS is ignored.
- stream_id, new_stream_id and enable change only in LOOKUP/LOAD.

Test Plan:
- Reset, then key 0x1234 packet of 5 bytes -> new_stream_id=1, stream_id=0, load_state pulse, char_in_vld high for 5 cycles starting 4 cycles after sop, eop exactly EOP_GAP+1 cycles after last char_in_vld, one result with res_stream_id=0, res_new=1.
- Second packet with key 0x1234 -> new_stream_id=0, stream_id=0. A packet with key 0x5678 -> stream_id=1, new=1.
- cfg_we stream 0, mask 0x05; matcher fired=0xFF during key 0x1234 packet -> enable=0x05, res_fired=0x05.
- 65 distinct keys -> 65th allocates stream_id 0 (wrap) with new=1. Reusing the first key is then a miss, allocated at stream_id 1.
- Hold res_rdy=0 for 10 cycles with the next packet pending -> res_vld and res_* stable, pkt_rdy=0, no load_state. After res_rdy, the next load_state follows 3 cycles later.
- 3 non-sop bytes in IDLE -> drop_cnt=3, no matcher activity. Assert rst_n=0 mid-STREAM -> all outputs 0 next cycle, no result emitted.
